stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Run/stop/lap sequencer for the board stopwatch.
- Debounces two raw push-buttons and runs a four-state controller.
- Drives the stopwatch counter's enable-tick and clear, and chooses which BCD value goes to the seven-segment controller: live count or a frozen lap snapshot.
- Also drives the decimal-point mask.
- Sits between the board buttons, the BCD digit counter and SevenSegmentControl.

Parameters:
- TICK_DIV, 1000000: clk cycles per count tick (100 MHz / 100 Hz = hundredths of a second).
- DEBOUNCE_CYCLES, 1000000: consecutive identical synchronized samples needed to accept a button level change (10 ms).

Ports:
- clk  input  1  system clock, single domain.
- rst_n  input  1  asynchronous active-low reset.
- btn_start  input  1  raw start/stop button, asynchronous, active-high.
- btn_lap  input  1  raw lap/clear button, asynchronous, active-high.
- digits_live  input  16  live BCD count {d3,d2,d1,d0} from the counter.
- tick  output  1  one-cycle count-enable pulse to the counter.
- count_clr  output  1  one-cycle synchronous clear pulse to the counter.
- digits_out  output  16  BCD value to the display controller.
- dp_n  output  4  active-low decimal-point mask to the display controller.
- state  output  2  current state: 00 IDLE, 01 RUN, 10 LAP, 11 STOPPED.

Behaviour:
- Reset (rst_n low, async) forces:
  - state=IDLE
  - tick=0, count_clr=0
  - lap register=16'h0000
  - divider=0
  - synchronizers=0, debounced levels=0, debounce counters=0
  - dp_n=4'b1011
  - digits_out=digits_live
- Reset may assert at any cycle, mid-operation; all of the above takes effect immediately.
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter increments while the synced sample differs from the debounced level, and resets to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level takes the sample and the counter clears.
  - Press event = one-cycle pulse on a debounced 0->1 edge. Release produces no event.
- The FSM samples press events; the state change is visible the cycle after the pulse.
- Same-cycle start and lap press: start wins, lap is discarded.
- State transitions:
  - IDLE: start -> RUN. Lap -> stay in IDLE, no clr.
  - RUN: start -> STOPPED. Lap -> LAP, and the lap register captures digits_live in the same edge.
  - LAP: start -> STOPPED. Lap -> RUN (display returns to live).
  - STOPPED: start -> RUN. Lap -> IDLE, with count_clr=1 for exactly one cycle, registered with the transition edge.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - tick=1 for the single cycle in which divider==TICK_DIV-1; the divider then wraps to 0.
  - Holds its value in STOPPED, so resume continues the partial period.
  - Forced to 0 in IDLE.
  - tick is never asserted outside RUN/LAP.
- Output mux:
  - digits_out = lap register in LAP, else digits_live (combinational mux, registered select).
- dp_n:
  - 4'b1011 (point after d2, separating seconds from hundredths) in IDLE, RUN, STOPPED.
  - 4'b1010 in LAP (d0 point lit as lap indicator).
- Width rules: TICK_DIV >= 2 and DEBOUNCE_CYCLES >= 2 are required. Counter widths are $clog2 of the parameter.

Test Plan (TICK_DIV=10, DEBOUNCE_CYCLES=4):
- Reset then idle 100 cycles -> state=00, tick never 1, dp_n=4'b1011, digits_out tracks digits_live=16'h1234.
- Glitchy btn_start held high for 2 cycles, low, repeated -> no state change. Held 10 cycles -> exactly one press, state=01; ticks every 10 cycles; 50 cycles yield 5 ticks.
- RUN, digits_live=16'h0412, press lap -> state=10, digits_out=16'h0412 while digits_live advances, ticks continue, dp_n=4'b1010. Press lap again -> state=01, digits_out=live.
- RUN with divider at 6, press start -> state=11, no ticks for 40 cycles. Press start -> first tick 3 cycles after entering RUN.
- STOPPED, press lap -> count_clr high exactly one cycle, state=00, divider=0. Subsequent start gives first tick after 10 cycles.
- Both buttons pressed simultaneously in RUN -> state=11, lap register unchanged. Assert rst_n=0 mid-LAP -> state=00, lap register=0, tick=0 immediately.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Run/stop/lap controller for the board stopwatch: button conditioning,
// four-state sequencer, count-tick divider and lap/live display selection.

module stopwatch_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);
  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Synchronize, then accept a new level only after CYCLES stable samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_btn_start,
  input  logic        i_btn_lap,
  input  logic [15:0] i_digits_live,
  output logic        o_tick,
  output logic        o_count_clr,
  output logic [15:0] o_digits_out,
  output logic [3:0]  o_dp_n,
  output logic [1:0]  o_state
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LAP  = 2'b10,
    S_STOP = 2'b11
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_start;
  logic          w_lap;
  logic          w_lap_ev;
  logic [15:0]   r_lap;
  logic [DW-1:0] r_div;
  logic          r_clr;

  stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_start),
    .o_press (w_start)
  );

  stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_lap),
    .o_press (w_lap)
  );

  // Start has priority: a lap press in the same cycle is dropped.
  assign w_lap_ev = w_lap & ~w_start;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode from debounced press events.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_RUN;
        else         w_next = S_IDLE;
      end
      S_RUN: begin
        if (w_start)       w_next = S_STOP;
        else if (w_lap_ev) w_next = S_LAP;
        else               w_next = S_RUN;
      end
      S_LAP: begin
        if (w_start)       w_next = S_STOP;
        else if (w_lap_ev) w_next = S_RUN;
        else               w_next = S_LAP;
      end
      S_STOP: begin
        if (w_start)       w_next = S_RUN;
        else if (w_lap_ev) w_next = S_IDLE;
        else               w_next = S_STOP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Lap snapshot and one-shot counter clear, both tied to the transition edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lap <= 16'h0000;
      r_clr <= 1'b0;
    end else begin
      r_clr <= (r_state == S_STOP) && (w_next == S_IDLE);
      if ((r_state == S_RUN) && (w_next == S_LAP)) begin
        r_lap <= i_digits_live;
      end else begin
        r_lap <= r_lap;
      end
    end
  end

  // Tick divider: runs in RUN/LAP, holds in STOP so resume keeps the partial period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
    end else if ((r_state == S_IDLE) || (w_next == S_IDLE)) begin
      r_div <= '0;
    end else if ((r_state == S_RUN) || (r_state == S_LAP)) begin
      if (r_div == DIV_LAST) r_div <= '0;
      else                   r_div <= r_div + DW'(1);
    end else begin
      r_div <= r_div;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    o_tick       = 1'b0;
    o_dp_n       = 4'b1011;
    o_digits_out = i_digits_live;
    case (r_state)
      S_RUN: begin
        o_tick = (r_div == DIV_LAST);
      end
      S_LAP: begin
        o_tick       = (r_div == DIV_LAST);
        o_dp_n       = 4'b1010;
        o_digits_out = r_lap;
      end
      default: begin
        o_tick       = 1'b0;
        o_dp_n       = 4'b1011;
        o_digits_out = i_digits_live;
      end
    endcase
  end

  assign o_count_clr = r_clr;
  assign o_state     = r_state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYCLES=4;
// expectations are queued at stimulus time and compared when outputs settle.

module tb_stopwatch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_start;
  logic        btn_lap;
  logic [15:0] digits_live;
  logic        tick;
  logic        count_clr;
  logic [15:0] digits_out;
  logic [3:0]  dp_n;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int clr_cnt = 0;
  int bad_tick = 0;
  int chg_at, tick_at, clr_at, t0, c0;
  bit found;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_start   (btn_start),
    .i_btn_lap     (btn_lap),
    .i_digits_live (digits_live),
    .o_tick        (tick),
    .o_count_clr   (count_clr),
    .o_digits_out  (digits_out),
    .o_dp_n        (dp_n),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // One clock: advance to the falling edge and account for pulses seen.
  task automatic step();
    @(negedge clk);
    if (tick) tick_cnt++;
    if (count_clr) clr_cnt++;
    if (tick && (state == 2'b00 || state == 2'b11)) bad_tick++;
  endtask

  // Hold the given buttons 10 cycles, release, and record when things happen.
  task automatic press(input logic s, input logic l, input int ncyc);
    logic [1:0] st0;
    st0 = state;
    chg_at = -1; tick_at = -1; clr_at = -1;
    btn_start = s;
    btn_lap = l;
    for (int i = 1; i <= ncyc; i++) begin
      step();
      if (tick && tick_at < 0) tick_at = i;
      if (count_clr && clr_at < 0) clr_at = i;
      if (state != st0 && chg_at < 0) chg_at = i;
      if (i == 10) begin
        btn_start = 1'b0;
        btn_lap = 1'b0;
      end
    end
  endtask

  task automatic wait_tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (tick) found = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_start = 1'b0;
    btn_lap = 1'b0;
    digits_live = 16'h1234;
    repeat (3) step();
    sb_push("rst_state", 32'h0); sb_push("rst_tick", 32'h0);
    sb_push("rst_clr", 32'h0); sb_push("rst_dp", 32'hB);
    sb_push("rst_digits", 32'h1234);
    sb_check(32'(state)); sb_check(32'(tick)); sb_check(32'(count_clr));
    sb_check(32'(dp_n)); sb_check(32'(digits_out));

    rst_n = 1'b1;
    t0 = tick_cnt;
    repeat (50) step();
    digits_live = 16'h5678;
    repeat (50) step();
    sb_push("idle_state", 32'h0); sb_push("idle_ticks", 32'h0);
    sb_push("idle_dp", 32'hB); sb_push("idle_digits", 32'h5678);
    sb_check(32'(state)); sb_check(32'(tick_cnt - t0));
    sb_check(32'(dp_n)); sb_check(32'(digits_out));

    // Short glitches must never be accepted.
    repeat (5) begin
      btn_start = 1'b1; step(); step();
      btn_start = 1'b0; step(); step();
    end
    repeat (10) step();
    sb_push("glitch_state", 32'h0);
    sb_check(32'(state));

    sb_push("start_chg", 32'd7); sb_push("start_tick", 32'd16); sb_push("start_state", 32'h1);
    press(1'b1, 1'b0, 20);
    sb_check(32'(chg_at)); sb_check(32'(tick_at)); sb_check(32'(state));
    t0 = tick_cnt;
    repeat (50) step();
    sb_push("run_ticks50", 32'd5);
    sb_check(32'(tick_cnt - t0));

    digits_live = 16'h0412;
    sb_push("lap_chg", 32'd7); sb_push("lap_state", 32'h2); sb_push("lap_dp", 32'hA);
    press(1'b0, 1'b1, 20);
    sb_check(32'(chg_at)); sb_check(32'(state)); sb_check(32'(dp_n));
    digits_live = 16'h0413;
    t0 = tick_cnt;
    repeat (30) step();
    digits_live = 16'h0500;
    step();
    sb_push("lap_frozen", 32'h0412); sb_push("lap_ticks30", 32'd3);
    sb_check(32'(digits_out)); sb_check(32'(tick_cnt - t0));

    sb_push("unlap_chg", 32'd7); sb_push("unlap_state", 32'h1);
    sb_push("unlap_digits", 32'h0500); sb_push("unlap_dp", 32'hB);
    press(1'b0, 1'b1, 20);
    sb_check(32'(chg_at)); sb_check(32'(state)); sb_check(32'(digits_out)); sb_check(32'(dp_n));

    // Stop right at a tick so the divider freezes at 6.
    wait_tick();
    sb_push("sync_tick_found", 32'h1);
    sb_check(32'(found));
    sb_push("stop_chg", 32'd7); sb_push("stop_notick", 32'hFFFF_FFFF); sb_push("stop_state", 32'h3);
    press(1'b1, 1'b0, 20);
    sb_check(32'(chg_at)); sb_check(32'(tick_at)); sb_check(32'(state));
    t0 = tick_cnt;
    repeat (27) step();
    sb_push("stopped_ticks", 32'h0);
    sb_check(32'(tick_cnt - t0));

    sb_push("resume_chg", 32'd7); sb_push("resume_tick", 32'd10); sb_push("resume_state", 32'h1);
    press(1'b1, 1'b0, 20);
    sb_check(32'(chg_at)); sb_check(32'(tick_at)); sb_check(32'(state));

    sb_push("stop2_state", 32'h3);
    press(1'b1, 1'b0, 20);
    sb_check(32'(state));
    c0 = clr_cnt;
    sb_push("clear_chg", 32'd7); sb_push("clear_clr_at", 32'd7);
    sb_push("clear_pulses", 32'd1); sb_push("clear_state", 32'h0);
    press(1'b0, 1'b1, 20);
    sb_check(32'(chg_at)); sb_check(32'(clr_at)); sb_check(32'(clr_cnt - c0)); sb_check(32'(state));
    sb_push("restart_tick", 32'd16); sb_push("restart_state", 32'h1);
    press(1'b1, 1'b0, 20);
    sb_check(32'(tick_at)); sb_check(32'(state));

    sb_push("both_chg", 32'd7); sb_push("both_state", 32'h3);
    press(1'b1, 1'b1, 20);
    sb_check(32'(chg_at)); sb_check(32'(state));

    sb_push("rerun_state", 32'h1);
    press(1'b1, 1'b0, 20);
    sb_check(32'(state));
    digits_live = 16'h0777;
    sb_push("lap2_state", 32'h2); sb_push("lap2_digits", 32'h0777);
    press(1'b0, 1'b1, 20);
    sb_check(32'(state)); sb_check(32'(digits_out));
    digits_live = 16'h0555;
    wait_tick();
    sb_push("lap2_tick_found", 32'h1);
    sb_check(32'(found));

    // Asynchronous reset in the middle of a tick cycle.
    rst_n = 1'b0;
    #1;
    sb_push("arst_state", 32'h0); sb_push("arst_tick", 32'h0);
    sb_push("arst_digits", 32'h0555); sb_push("arst_dp", 32'hB); sb_push("arst_clr", 32'h0);
    sb_check(32'(state)); sb_check(32'(tick)); sb_check(32'(digits_out));
    sb_check(32'(dp_n)); sb_check(32'(count_clr));
    repeat (3) step();
    rst_n = 1'b1;
    step();
    sb_push("post_rst_chg", 32'd7); sb_push("post_rst_tick", 32'd16); sb_push("post_rst_state", 32'h1);
    press(1'b1, 1'b0, 20);
    sb_check(32'(chg_at)); sb_check(32'(tick_at)); sb_check(32'(state));

    sb_push("tick_outside_run", 32'h0);
    sb_check(32'(bad_tick));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
